// File: rtl/pseudorandom_wb.sv
// ----------------------------------------------------------------------------
// pseudorandom_wb
//   Wishbone-slave xorshift32 pseudorandom number generator.
//
//   Register map (byte offsets inside the BASE_ADDR window, decoded on adr[3:2]):
//     0x00 CTRL  RW  bit0 RUN  : advance the state every clock
//                    bit1 AUTO : advance the state after each DATA read
//     0x04 SEED  WO  byte-merged load of the state; zero loads DEFAULT_SEED;
//                    clears COUNT; reads as 0
//     0x08 DATA  RO  current state (pre-advance value)
//     0x0C COUNT RO  advances since the last seed or reset (wraps)
//
//   Ports:
//     clk       system / Wishbone clock
//     rst_n     asynchronous active-low reset
//     wb_cyc_i  bus cycle valid
//     wb_stb_i  strobe
//     wb_we_i   1 = write
//     wb_sel_i  byte lanes (writes only)
//     wb_adr_i  byte address
//     wb_dat_i  write data
//     wb_dat_o  read data, valid while wb_ack_o = 1
//     wb_ack_o  single-cycle acknowledge
// ----------------------------------------------------------------------------
module pseudorandom_wb #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [31:0] DEFAULT_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o
);

    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_SEED  = 2'd1,
        REG_DATA  = 2'd2,
        REG_COUNT = 2'd3
    } reg_e;

    localparam logic [1:0] CTRL_RESET = 2'b10;

    // xorshift32 step; a nonzero state never maps to zero.
    function automatic logic [31:0] xorshift32_step(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    logic [31:0] state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [1:0]  ctrl_q,  ctrl_d;
    logic        ack_q,   ack_d;
    logic [31:0] dat_q,   dat_d;

    logic        sel_hit;
    logic        take;
    logic        is_rd;
    logic        is_wr;
    reg_e        reg_sel;
    logic        seed_wr;
    logic        auto_rd;
    logic        advance;
    logic [31:0] merged;

    // Address bits outside the decode are intentionally ignored.
    logic        unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[7:4], wb_adr_i[1:0]};

    always_comb begin
        sel_hit = wb_cyc_i & wb_stb_i & (wb_adr_i[31:8] == BASE_ADDR[31:8]);
        // No new access is accepted while an ack is high, so a held strobe
        // is acknowledged once per two cycles.
        take    = sel_hit & ~ack_q;
        is_rd   = take & ~wb_we_i;
        is_wr   = take &  wb_we_i;
        reg_sel = reg_e'(wb_adr_i[3:2]);

        ctrl_d = ctrl_q;
        if (is_wr && (reg_sel == REG_CTRL) && wb_sel_i[0]) begin
            ctrl_d = wb_dat_i[1:0];
        end

        merged[7:0]   = wb_sel_i[0] ? wb_dat_i[7:0]   : state_q[7:0];
        merged[15:8]  = wb_sel_i[1] ? wb_dat_i[15:8]  : state_q[15:8];
        merged[23:16] = wb_sel_i[2] ? wb_dat_i[23:16] : state_q[23:16];
        merged[31:24] = wb_sel_i[3] ? wb_dat_i[31:24] : state_q[31:24];

        seed_wr = is_wr && (reg_sel == REG_SEED);
        auto_rd = is_rd && (reg_sel == REG_DATA) && ctrl_q[1];
        // RUN and an AUTO read coinciding still yield a single step.
        advance = ctrl_q[0] | auto_rd;

        state_d = state_q;
        count_d = count_q;
        if (seed_wr) begin
            state_d = (merged == '0) ? DEFAULT_SEED : merged;
            count_d = '0;
        end else if (advance) begin
            state_d = xorshift32_step(state_q);
            count_d = count_q + 32'd1;
        end

        // Read data reflects register values before this edge's update.
        dat_d = '0;
        if (is_rd) begin
            unique case (reg_sel)
                REG_CTRL:  dat_d = {30'd0, ctrl_q};
                REG_SEED:  dat_d = '0;
                REG_DATA:  dat_d = state_q;
                REG_COUNT: dat_d = count_q;
            endcase
        end

        ack_d = take;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DEFAULT_SEED;
            count_q <= '0;
            ctrl_q  <= CTRL_RESET;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_pseudorandom_wb.sv
// ----------------------------------------------------------------------------
// tb_pseudorandom_wb
//   Directed-vector bench for pseudorandom_wb. Each access pushes its expected
//   response onto a scoreboard queue; a monitor pops and compares on every ack.
// ----------------------------------------------------------------------------
module tb_pseudorandom_wb;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_SEED = BASE + 32'h4;
    localparam logic [31:0] A_DATA = BASE + 32'h8;
    localparam logic [31:0] A_CNT  = BASE + 32'hC;

    logic        clk;
    logic        rst_n;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          chk_data;
    } sb_t;

    sb_t sb_q[$];

    pseudorandom_wb #(
        .BASE_ADDR    (32'h3000_0000),
        .DEFAULT_SEED (32'h0000_0001)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] step_n(input logic [31:0] s, input int n);
        logic [31:0] t;
        logic [31:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            t = v ^ (v << 13);
            t = t ^ (t >> 17);
            v = t ^ (t << 5);
        end
        return v;
    endfunction

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wb_ack_o) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack with data %08h, required no ack", wb_dat_o);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.chk_data && (wb_dat_o !== e.exp)) begin
                    errors++;
                    $display("FAIL %s: got %08h, required %08h", e.name, wb_dat_o, e.exp);
                end
            end
        end
    end

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, required %08h", name, got, exp);
        end
    endtask

    // Called on a negedge; the access is taken on the following posedge and
    // returns one idle cycle later so consecutive calls are never blocked.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic [31:0] exp,
                             input bit chk, input string name);
        sb_t e;
        e.name = name;
        e.exp = exp;
        e.chk_data = chk;
        sb_q.push_back(e);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        @(posedge clk);
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_access(1'b1, adr, dat, sel, 32'h0, 1'b0, "write_ack");
    endtask

    task automatic wb_rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        wb_access(1'b0, adr, 32'h0, 4'hF, exp, 1'b1, name);
    endtask

    // Unqualified access: nothing is pushed, so any ack trips the monitor.
    task automatic wb_noack(input logic cyc, input logic [31:0] adr, input string name);
        wb_cyc_i = cyc;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = adr;
        wb_sel_i = 4'hF;
        @(posedge clk);
        #1;
        check_now(name, {31'd0, wb_ack_o}, 32'h0);
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'h0;
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_ack", {31'd0, wb_ack_o}, 32'h0);
        check_now("reset_dat", wb_dat_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset defaults: AUTO on, state 1.
        wb_rd(A_CTRL, 32'h2, "ctrl_reset");
        wb_rd(A_DATA, 32'h0000_0001, "auto_read1");
        wb_rd(A_DATA, 32'h0004_2021, "auto_read2");
        wb_rd(A_CNT,  32'd2,         "count_after_two");

        // Seed and sequence.
        wb_wr(A_SEED, 32'h0000_0001, 4'hF);
        wb_rd(A_DATA, 32'h0000_0001, "seq0");
        wb_rd(A_DATA, 32'h0004_2021, "seq1");
        wb_rd(A_DATA, 32'h0408_0601, "seq2");
        wb_rd(A_SEED, 32'h0,         "seed_reads_zero");

        // Zero seed substitutes the default.
        wb_wr(A_SEED, 32'h0000_0000, 4'hF);
        wb_rd(A_DATA, 32'h0000_0001, "zero_seed");

        // AUTO off: DATA is stable, COUNT frozen at the single advance above.
        wb_wr(A_CTRL, 32'h0, 4'hF);
        wb_rd(A_CTRL, 32'h0, "ctrl_zero");
        for (int i = 0; i < 5; i++) wb_rd(A_DATA, 32'h0004_2021, "stable_data");
        wb_rd(A_CNT, 32'd1, "count_frozen");

        // RUN together with an AUTO read gives one advance in that cycle.
        wb_wr(A_SEED, 32'h0000_0001, 4'hF);
        wb_wr(A_CTRL, 32'h3, 4'hF);
        wb_rd(A_DATA, 32'h0004_2021, "run_auto_data");
        wb_wr(A_CTRL, 32'h0, 4'hF);
        wb_rd(A_CNT,  32'd4, "run_auto_count");
        wb_rd(A_DATA, step_n(32'h1, 4), "run_auto_state");

        // RUN for 100 idle clocks: advances from the CTRL=1 ack edge+1 through
        // the CTRL=0 ack edge inclusive (102 edges with this bus timing).
        wb_wr(A_SEED, 32'h0000_0001, 4'hF);
        wb_wr(A_CTRL, 32'h1, 4'hF);
        repeat (100) @(negedge clk);
        wb_wr(A_CTRL, 32'h0, 4'hF);
        wb_rd(A_CNT,  32'd102, "run_count");
        wb_rd(A_DATA, step_n(32'h1, 102), "run_state");

        // Partial seed write on lane 0 only.
        wb_wr(A_SEED, 32'h0000_0001, 4'hF);
        wb_wr(A_SEED, 32'hFFFF_FF05, 4'b0001);
        wb_rd(A_DATA, 32'h0000_0005, "partial_seed");

        // Writes to DATA are acknowledged but ignored.
        wb_wr(A_DATA, 32'hDEAD_BEEF, 4'hF);
        wb_rd(A_DATA, 32'h0000_0005, "data_write_ignored");

        // Unqualified cycles.
        wb_noack(1'b1, 32'h3000_0108, "wrong_window");
        wb_noack(1'b0, A_DATA,        "cyc_low");

        // Held strobe: one ack per two cycles.
        begin
            sb_t e;
            e.name = "held_strobe";
            e.exp = 32'h0;
            e.chk_data = 1'b1;
            sb_q.push_back(e);
            sb_q.push_back(e);
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
            wb_we_i  = 1'b0;
            wb_adr_i = A_CTRL;
            repeat (4) @(posedge clk);
            @(negedge clk);
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            @(negedge clk);
        end
        check_now("held_strobe_acks", sb_q.size(), 32'd0);

        // Asynchronous reset while an ack is high drops it at once.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = A_DATA;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset_ack", {31'd0, wb_ack_o}, 32'h0);
        check_now("async_reset_dat", wb_dat_o, 32'h0);
        @(negedge clk);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wb_rd(A_CTRL, 32'h2,         "post_reset_ctrl");
        wb_rd(A_CNT,  32'h0,         "post_reset_count");
        wb_rd(A_DATA, 32'h0000_0001, "post_reset_data");

        repeat (2) @(negedge clk);
        check_now("missing_acks", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
